// File: rtl/sop_pkg.sv
// Shared constants and sizing helpers for the pipeline register chain.
package sop_pkg;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    // Width needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit and a data register with load/advance control.
module pipe_stage #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_advance,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its neighbours' pre-edge values, whatever order the simulator runs them in.
    always_ff @(posedge clk) begin
        // NOTE: the data register is reset as well as the valid bit, so out_data
        // reads 0 after reset instead of a stale or unknown word.
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_clear)        r_valid <= 1'b0;
            else if (i_load)    r_valid <= 1'b1;
            else if (i_advance) r_valid <= 1'b0;

            if (i_load && !i_clear) r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg_chain.sv
// Bubble-collapsing valid/ready register chain of DEPTH stages with flush and occupancy.
module pipe_reg_chain
    import sop_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0]      w_valid;
    logic [DEPTH-1:0]      w_adv;
    logic [DEPTH-1:0]      w_load;
    logic [DATA_WIDTH-1:0] w_data [DEPTH];
    logic [DATA_WIDTH-1:0] w_din  [DEPTH];

    // A stage advances when it is valid and some stage downstream of it is empty
    // or the tail is draining; this is the unrolled form of "next empty or advancing".
    always_comb begin
        logic room;
        // NOTE: every combinational output gets a default before the loop so no
        // path leaves a bit unassigned, which would infer a latch.
        w_adv = '0;
        room  = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_adv[k] = w_valid[k] & room;
            room     = room | ~w_valid[k];
        end
    end

    assign in_ready = rst & ~flush & (~w_valid[0] | w_adv[0]);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_load[k] = in_valid & in_ready;
            assign w_din[k]  = in_data;
        end else begin : g_body
            assign w_load[k] = w_adv[k-1];
            assign w_din[k]  = w_data[k-1];
        end

        pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_clear   (flush),
            .i_load    (w_load[k]),
            .i_advance (w_adv[k]),
            .i_data    (w_din[k]),
            .o_valid   (w_valid[k]),
            .o_data    (w_data[k])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(w_valid[k]);
        end
    end

    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];

endmodule
